brew_dispense_module: RTL and testbench
=======================================

BREW_DISPENSE_MODULE -- requirements
Module: brew_dispense_module

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per brew tick (one second at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  purchase-accepted strobe, driven by the price/change stage enable_timer.
REQ-005 SHALL have port coffee_type  input  3  drink code: 0 espresso, 1 coffee and milk, 2 cappuccino, 3 mocaccino.
REQ-006 SHALL have port change  input  4  number of change coins owed, from the price/change stage.
REQ-007 SHALL have port coin_ack  input  1  coin ejector has released one coin.
REQ-008 SHALL have port coin_out  output  1  request to the ejector for one coin.
REQ-009 SHALL have port brewing  output  1  high while the drink is being brewed.
REQ-010 SHALL have port time_left  output  4  brew ticks remaining; 0 outside BREW.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the order completes.

Function
REQ-013 SHALL implement the FSM states IDLE, BREW, CHANGE and DONE.
REQ-014 In IDLE, start=1 with coffee_type of 0..3 SHALL latch type and change, load the tick counter with BREW_TICKS[type], clear the prescaler, and enter BREW on the next edge.
REQ-015 In IDLE, start=1 with coffee_type of 4..7 SHALL be ignored; the block stays in IDLE and all outputs are unchanged.
REQ-016 start SHALL be ignored in every state except IDLE; it has no effect on the latched values.
REQ-017 BREW_TICKS SHALL be: espresso 5, coffee and milk 6, cappuccino 8, mocaccino 10.
REQ-018 In BREW, the prescaler SHALL increment every cycle; at TICK_DIV-1 it wraps to 0 and the tick counter decrements.
REQ-019 The decrement of the tick counter from 1 to 0 SHALL exit BREW on that same edge, so BREW lasts exactly BREW_TICKS*TICK_DIV cycles.
REQ-020 On exit from BREW, the next state SHALL be CHANGE if the latched change is greater than 0, else DONE.
REQ-021 In CHANGE, coin_out SHALL be 1; each cycle with coin_ack=1 decrements the coins-left count.
REQ-022 An ack that takes coins-left from 1 to 0 SHALL move to DONE.
REQ-023 coin_ack SHALL be ignored whenever coin_out=0.
REQ-024 Coins-left SHALL never underflow; change=15 yields exactly 15 coin grants.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 A new start SHALL be accepted in IDLE on the cycle after DONE.
REQ-027 brewing SHALL be 1 only in BREW.
REQ-028 time_left SHALL equal the tick counter in BREW and 0 elsewhere.
REQ-029 All outputs SHALL be registered or decoded from the state and registers only, with no combinational path from any input.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and clear the prescaler, tick counter, coins-left, latched type and latched change.
REQ-031 During rst=1, outputs SHALL be: coin_out 0, brewing 0, time_left 0, busy 0, done 0.
REQ-032 Reset asserted mid-BREW or mid-CHANGE SHALL abandon the order; no done pulse and no further coin_out are produced.
REQ-033 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-034 A shared package SHALL hold the drink-code enum (ESPRESSO=0, COFFEE_MILK=1, CAPPUCCINO=2, MOCACCINO=3) and the BREW_TICKS constants; the price/change stage uses the same package.
REQ-035 The FSM state enum SHALL stay local to the block.
REQ-036 The prescaler SHALL be a sub-module, tick_prescaler, with ports clk, rst, clear and tick, parameterised by TICK_DIV.

Verification (TICK_DIV=4)
REQ-037 Scenario: start with type 0 and change 2; ack each coin_out 1 cycle later. Required: brewing high for 20 cycles with time_left 5..1; exactly 2 coins granted; one done pulse; then IDLE.
REQ-038 Scenario: start with type 3 and change 0. Required: brewing for 40 cycles, then done directly with coin_out never high.
REQ-039 Scenario: start with type 5. Required: busy stays 0 and no state change.
REQ-040 Scenario: start pulsed again mid-BREW with type 0. Required: the original type 2 timing of 32 cycles holds, and the latched change is unchanged.
REQ-041 Scenario: change 15 with coin_ack held at 1 continuously. Required: exactly 15 acks counted, then DONE; spurious acks in IDLE are ignored.
REQ-042 Scenario: rst asserted asynchronously mid-CHANGE after 1 of 3 coins. Required: coin_out and busy drop without waiting for a clock, with no done pulse; a fresh start afterwards works normally.

Source files
------------

// File: rtl/brew_dispense_module_pkg.sv
// Shared drink definitions used by the price/change stage and the brew/dispense stage.
package brew_dispense_module_pkg;

    typedef enum logic [2:0] {
        ESPRESSO    = 3'd0,
        COFFEE_MILK = 3'd1,
        CAPPUCCINO  = 3'd2,
        MOCACCINO   = 3'd3
    } drink_t;

    localparam logic [3:0] ESPRESSO_TICKS    = 4'd5;
    localparam logic [3:0] COFFEE_MILK_TICKS = 4'd6;
    localparam logic [3:0] CAPPUCCINO_TICKS  = 4'd8;
    localparam logic [3:0] MOCACCINO_TICKS   = 4'd10;

    // Brew duration in ticks for a drink; undefined codes brew for zero ticks.
    function automatic logic [3:0] brew_ticks(input drink_t d);
        case (d)
            ESPRESSO:    return ESPRESSO_TICKS;
            COFFEE_MILK: return COFFEE_MILK_TICKS;
            CAPPUCCINO:  return CAPPUCCINO_TICKS;
            MOCACCINO:   return MOCACCINO_TICKS;
            default:     return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/brew_dispense_module_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles while not cleared.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap; held at zero while cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tick is decoded from the register so it never depends on inputs directly.
    always_comb begin
        tick = (cnt_q == LAST);
    end

endmodule

// File: rtl/brew_dispense_module.sv
// Brew/dispense stage: times the brew for the purchased drink, pays out change, then signals done.
module brew_dispense_module
    import brew_dispense_module_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] coffee_type,
    input  logic [3:0] change,
    input  logic       coin_ack,
    output logic       coin_out,
    output logic       brewing,
    output logic [3:0] time_left,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREW   = 2'd1,
        CHANGE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ticks_q, ticks_d;
    logic [3:0] coins_q, coins_d;
    drink_t     type_q, type_d;
    logic [3:0] change_q, change_d;
    logic       tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q != BREW),
        .tick (tick)
    );

    // State and order registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ticks_q  <= '0;
            coins_q  <= '0;
            type_q   <= ESPRESSO;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            ticks_q  <= ticks_d;
            coins_q  <= coins_d;
            type_q   <= type_d;
            change_q <= change_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        ticks_d   = ticks_q;
        coins_d   = coins_q;
        type_d    = type_q;
        change_d  = change_q;
        coin_out  = 1'b0;
        brewing   = 1'b0;
        time_left = '0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !coffee_type[2]) begin
                    type_d   = drink_t'(coffee_type);
                    change_d = change;
                    ticks_d  = brew_ticks(drink_t'(coffee_type));
                    state_d  = BREW;
                end
            end
            BREW: begin
                brewing   = 1'b1;
                time_left = ticks_q;
                if (tick && ticks_q != '0) begin
                    ticks_d = ticks_q - 4'd1;
                    if (ticks_q == 4'd1) begin
                        if (change_q != '0) begin
                            coins_d = change_q;
                            state_d = CHANGE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            CHANGE: begin
                coin_out = 1'b1;
                if (coin_ack && coins_q != '0) begin
                    coins_d = coins_q - 4'd1;
                    if (coins_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sanity check: the remaining brew time never exceeds the latched drink's full duration.
    always_comb begin
        if (state_q == BREW) begin
            assert (ticks_q <= brew_ticks(type_q));
        end
    end

endmodule

// File: tb/tb_brew_dispense_module.sv
// Directed self-checking bench for brew_dispense_module with TICK_DIV=4.
module tb_brew_dispense_module;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] coffee_type;
    logic [3:0] change;
    logic       coin_ack;
    logic       coin_out;
    logic       brewing;
    logic [3:0] time_left;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    brew_dispense_module #(
        .TICK_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .coffee_type(coffee_type),
        .change     (change),
        .coin_ack   (coin_ack),
        .coin_out   (coin_out),
        .brewing    (brewing),
        .time_left  (time_left),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit in case something never ends.
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int coin_seen;

        rst = 1'b1; start = 1'b0; coffee_type = 3'd0; change = 4'd0; coin_ack = 1'b0;
        step(); step();
        chk("rst_coin_out", coin_out, 0);
        chk("rst_brewing", brewing, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // Espresso with two coins of change, each acked one cycle after coin_out.
        start = 1'b1; coffee_type = 3'd0; change = 4'd2;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("s1_brewing", brewing, 1);
            chk("s1_time_left", time_left, 32'(5 - k / 4));
            step();
        end
        chk("s1_change_entry_brewing", brewing, 0);
        chk("s1_change_entry_time", time_left, 0);
        chk("s1_coin_out_a", coin_out, 1);
        step();
        chk("s1_coin_out_b", coin_out, 1);
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        chk("s1_coin_out_c", coin_out, 1);
        chk("s1_done_early", done, 0);
        step();
        chk("s1_coin_out_d", coin_out, 1);
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        chk("s1_done", done, 1);
        chk("s1_done_coin_out", coin_out, 0);
        chk("s1_done_busy", busy, 1);
        step();
        chk("s1_idle_done", done, 0);
        chk("s1_idle_busy", busy, 0);

        // Mocaccino, no change: straight from brew to done.
        start = 1'b1; coffee_type = 3'd3; change = 4'd0;
        step();
        start = 1'b0;
        chk("s2_time_left", time_left, 10);
        n = 0; coin_seen = 0;
        while (brewing && n < 100) begin
            n++;
            if (coin_out) coin_seen = 1;
            step();
        end
        chk("s2_brew_cycles", n, 40);
        chk("s2_done", done, 1);
        chk("s2_coin_out", coin_out | coin_seen[0], 0);
        step();
        chk("s2_idle_busy", busy, 0);

        // Undefined drink code is ignored.
        start = 1'b1; coffee_type = 3'd5; change = 4'd3;
        step();
        start = 1'b0;
        chk("s3_busy", busy, 0);
        chk("s3_brewing", brewing, 0);
        chk("s3_time_left", time_left, 0);
        step();
        chk("s3_busy_later", busy, 0);
        chk("s3_coin_out", coin_out, 0);

        // Cappuccino with one coin; a second start mid-brew must not disturb it.
        start = 1'b1; coffee_type = 3'd2; change = 4'd1;
        step();
        start = 1'b0;
        chk("s4_time_left", time_left, 8);
        n = 0;
        while (brewing && n < 100) begin
            n++;
            start = (n == 5);
            coffee_type = (n == 5) ? 3'd0 : 3'd2;
            change = (n == 5) ? 4'd9 : 4'd1;
            step();
        end
        start = 1'b0;
        chk("s4_brew_cycles", n, 32);
        chk("s4_coin_out", coin_out, 1);
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        chk("s4_done_after_one", done, 1);
        step();
        chk("s4_idle_busy", busy, 0);

        // Fifteen coins with coin_ack held high throughout, including idle.
        coin_ack = 1'b1;
        step(); step();
        chk("s5_spurious_busy", busy, 0);
        chk("s5_spurious_coin_out", coin_out, 0);
        start = 1'b1; coffee_type = 3'd0; change = 4'd15;
        step();
        start = 1'b0;
        n = 0;
        while (brewing && n < 100) begin
            n++;
            step();
        end
        chk("s5_brew_cycles", n, 20);
        n = 0;
        while (coin_out && n < 100) begin
            n++;
            step();
        end
        chk("s5_coin_grants", n, 15);
        chk("s5_done", done, 1);
        step();
        coin_ack = 1'b0;
        chk("s5_idle_busy", busy, 0);

        // Asynchronous reset mid-change after one of three coins.
        start = 1'b1; coffee_type = 3'd1; change = 4'd3;
        step();
        start = 1'b0;
        n = 0;
        while (brewing && n < 100) begin
            n++;
            step();
        end
        chk("s6_brew_cycles", n, 24);
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        chk("s6_coin_out_pre", coin_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_coin_out", coin_out, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_done", done, 0);
        step();
        chk("s6_rst_hold_done", done, 0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (done || coin_out || busy) n++;
            step();
        end
        chk("s6_post_rst_quiet", n, 0);
        start = 1'b1; coffee_type = 3'd0; change = 4'd0;
        step();
        start = 1'b0;
        chk("s6_restart_brewing", brewing, 1);
        chk("s6_restart_time", time_left, 5);
        n = 0;
        while (brewing && n < 100) begin
            n++;
            step();
        end
        chk("s6_restart_cycles", n, 20);
        chk("s6_restart_done", done, 1);
        step();
        chk("s6_restart_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
